// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-fed one-bit-per-clock UART serialiser; in_* push port, tx line, busy/fifo_count status
module uart_transmitter #(
  parameter int DEPTH = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [6:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_bad_parity,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [2:0] {IDLE, START, PARITY, DATA, STOP} state_t;
  state_t state_q;
  logic [7:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] baud_q;
  logic [2:0] idx_q;
  logic [6:0] data_q;
  logic par_q, tx_q, busy_q;
  logic push, pop, bit_end, last_stop;
  logic [7:0] head;
  always_comb begin
    in_ready = (cnt_q != CW'(DEPTH)) && rstN;
    push = in_valid && in_ready;
    bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
    last_stop = state_q == STOP && bit_end && idx_q == 3'(STOP_BITS - 1);
    pop = cnt_q != '0 && (state_q == IDLE || last_stop);
    head = mem_q[rd_q];
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_bad_parity, in_data};
  end
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      baud_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_d;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);
      if (pop) begin
        data_q <= head[6:0];
        par_q <= ^head;
        state_q <= START;
        tx_q <= 1'b0;
        busy_q <= 1'b1;
        idx_q <= '0;
      end else if (bit_end) begin
        case (state_q)
          START: begin
            state_q <= PARITY;
            tx_q <= par_q;
          end
          PARITY: begin
            state_q <= DATA;
            tx_q <= data_q[0];
            idx_q <= '0;
          end
          DATA: begin
            state_q <= idx_q == 3'd6 ? STOP : DATA;
            tx_q <= idx_q == 3'd6 ? 1'b1 : data_q[1];
            data_q <= data_q >> 1;
            idx_q <= idx_q == 3'd6 ? '0 : idx_q + 3'd1;
          end
          STOP: begin
            state_q <= last_stop ? IDLE : STOP;
            busy_q <= !last_stop;
            idx_q <= idx_q + 3'd1;
            tx_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign fifo_count = cnt_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of frame format, latency, back-to-back, slow baud, reset and loopback
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic rstN;
  logic [6:0] in_data, in_data3;
  logic in_valid, in_bad_parity, in_valid3;
  logic in_ready, tx, busy, in_ready3, tx3, busy3;
  logic [2:0] fifo_count, fifo_count3;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  uart_transmitter dut (
    .clk(clk), .rstN(rstN), .in_data(in_data), .in_valid(in_valid),
    .in_bad_parity(in_bad_parity), .in_ready(in_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count)
  );
  uart_transmitter #(.DEPTH(4), .CLKS_PER_BIT(3), .STOP_BITS(2)) dut3 (
    .clk(clk), .rstN(rstN), .in_data(in_data3), .in_valid(in_valid3),
    .in_bad_parity(1'b0), .in_ready(in_ready3), .tx(tx3), .busy(busy3),
    .fifo_count(fifo_count3)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] frame_bits(input logic [6:0] d, input logic bad);
    return {1'b1, d, ^d ^ bad, 1'b0};
  endfunction
  task automatic push_frame(input logic [6:0] d, input logic bad, output logic [9:0] f,
                            output logic b_all, output logic idle_after);
    in_data = d;
    in_bad_parity = bad;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_bad_parity = 1'b0;
    b_all = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f[i] = tx;
      b_all &= busy;
    end
    @(negedge clk);
    idle_after = tx && !busy && fifo_count == 3'd0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [9:0] f;
    logic b_all, idle_after, acc, saw_full, full_ok, gap_free;
    logic tq [62];
    logic bq [62];
    logic [33:0] s3, b3;
    logic [32:0] exp3;
    logic [9:0] fe;
    logic [6:0] d;
    logic bad;
    int w;
    rstN = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_bad_parity = 1'b0;
    in_data3 = '0;
    in_valid3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_tx3", tx3, 1'b1);
    rstN = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);
    push_frame(7'h55, 1'b0, f, b_all, idle_after);
    check("f55", f, 10'b1101010100);
    check("f55_busy", b_all, 1'b1);
    check("f55_idle", idle_after, 1'b1);
    push_frame(7'h01, 1'b0, f, b_all, idle_after);
    check("f01", f, 10'b1000000110);
    check("f01_idle", idle_after, 1'b1);
    push_frame(7'h01, 1'b1, f, b_all, idle_after);
    check("f01_badpar", f, 10'b1000000100);
    check("f01_badpar_busy", b_all, 1'b1);
    w = 0;
    saw_full = 1'b0;
    full_ok = 1'b1;
    in_data = 7'h10;
    in_valid = 1'b1;
    for (int c = 0; c < 62; c++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin
        w++;
        in_data = 7'(7'h10 + w);
        if (w == 6) in_valid = 1'b0;
      end
      tq[c] = tx;
      bq[c] = busy;
      if (fifo_count == 3'd4) begin
        saw_full = 1'b1;
        if (in_ready) full_ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_latency", {tq[0], tq[1]}, 2'b10);
    check("b2b_pushed", w, 6);
    check("b2b_saw_full", saw_full, 1'b1);
    check("b2b_full_not_ready", full_ok, 1'b1);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 10; i++) f[i] = tq[1 + 10 * k + i];
      check($sformatf("b2b_frame%0d", k), f, frame_bits(7'(7'h10 + k), 1'b0));
    end
    gap_free = 1'b1;
    for (int c = 1; c < 61; c++) gap_free &= bq[c];
    check("b2b_busy_no_gap", gap_free, 1'b1);
    check("b2b_end_idle", {tq[61], bq[61]}, 2'b10);
    in_data3 = 7'h7F;
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      s3[i] = tx3;
      b3[i] = busy3;
    end
    check("cpb3_start", s3[2:0], 3'b000);
    check("cpb3_rest", s3[32:3], {30{1'b1}});
    check("cpb3_busy_len", $countones(b3), 33);
    check("cpb3_end", {s3[33], b3[33]}, 2'b10);
    in_data3 = 7'h0F;
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      s3[i] = tx3;
    end
    fe = frame_bits(7'h0F, 1'b0);
    for (int i = 0; i < 33; i++) exp3[i] = i < 27 ? fe[i / 3] : 1'b1;
    check("cpb3_0f", s3[32:0], exp3);
    check("cpb3_0f_idle", s3[33], 1'b1);
    in_data = 7'h00;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 7'h2A;
    @(negedge clk);
    in_data = 7'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_bit3", tx, 1'b0);
    check("mid_busy", busy, 1'b1);
    check("mid_count", fifo_count, 3'd2);
    rstN = 1'b0;
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 3'd0);
    rstN = 1'b1;
    push_frame(7'h55, 1'b0, f, b_all, idle_after);
    check("postrst_frame", f, 10'b1101010100);
    check("postrst_idle", idle_after, 1'b1);
    repeat (3) @(negedge clk);
    check("postrst_quiet", {tx, busy}, 2'b10);
    for (int i = 0; i < 8; i++) begin
      d = 7'($urandom_range(0, 127));
      bad = (i % 3) == 1;
      push_frame(d, bad, f, b_all, idle_after);
      check($sformatf("loop%0d_start_stop", i), {f[9], f[0]}, 2'b10);
      check($sformatf("loop%0d_data", i), f[8:2], d);
      check($sformatf("loop%0d_correct", i), f[1] == ^f[8:2], !bad);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
